// File: rtl/sha256_msg_padder.sv
// Purpose: pads a 32-bit big-endian word stream into SHA-256 512-bit blocks (0x80 marker, zero fill, 64-bit bit length).
// Latency: blk_valid rises 1 + (number of PAD cycles, <=15) cycles after the last word is accepted.
// Backpressure: while a block is held in EMIT, in_ready=0 and blk_data/blk_first/blk_final stay stable until blk_ready.
module sha256_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [2:0]   in_nbytes,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_first,
    output logic         blk_final
);

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        PAD    = 2'd1,
        EMIT   = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [3:0]       wcnt, wcnt_nx;
    logic [LEN_W-1:0] bitcnt, bitcnt_nx;
    logic             first_pend, first_pend_nx;
    logic             marker_done, marker_done_nx;
    // final_q: the block being built/held carries the length field
    logic             final_q, final_nx;
    // pad_after: where a non-final EMIT returns to (PAD when the message is already complete)
    logic             pad_after, pad_after_nx;

    logic             wr_en;
    logic [31:0]      wr_dat;
    logic             len_wr;
    logic [31:0]      buf_q [16];
    logic [63:0]      len64;
    logic [2:0]       nb_eff;
    logic [31:0]      last_word;
    logic             in_fire;

    assign in_ready  = (state == ACCEPT);
    assign in_fire   = in_valid && in_ready;
    assign blk_valid = (state == EMIT);
    assign blk_first = (state == EMIT) && first_pend;
    assign blk_final = (state == EMIT) && final_q;
    assign len64     = 64'(bitcnt);

    // Effective byte count of the incoming word and its marker-padded form
    always_comb begin
        nb_eff    = 3'd4;
        last_word = in_data;
        if (in_last && in_nbytes != 3'd0 && in_nbytes < 3'd4) begin
            nb_eff = in_nbytes;
        end
        case (nb_eff)
            3'd1:    last_word = (in_data & 32'hFF00_0000) | 32'h0080_0000;
            3'd2:    last_word = (in_data & 32'hFFFF_0000) | 32'h0000_8000;
            3'd3:    last_word = (in_data & 32'hFFFF_FF00) | 32'h0000_0080;
            default: last_word = in_data;
        endcase
    end

    // Next-state and buffer write control
    always_comb begin
        state_nx       = state;
        wcnt_nx        = wcnt;
        bitcnt_nx      = bitcnt;
        first_pend_nx  = first_pend;
        marker_done_nx = marker_done;
        final_nx       = final_q;
        pad_after_nx   = pad_after;
        wr_en          = 1'b0;
        wr_dat         = 32'h0;
        len_wr         = 1'b0;
        case (state)
            ACCEPT: begin
                if (in_fire) begin
                    wr_en     = 1'b1;
                    wr_dat    = last_word;
                    bitcnt_nx = bitcnt + LEN_W'({nb_eff, 3'b000});
                    final_nx  = 1'b0;
                    if (!in_last) begin
                        pad_after_nx = 1'b0;
                        if (wcnt == 4'd15) state_nx = EMIT;
                        else               wcnt_nx  = wcnt + 4'd1;
                    end else begin
                        pad_after_nx   = 1'b1;
                        marker_done_nx = (nb_eff != 3'd4);
                        if (wcnt == 4'd15) begin
                            state_nx = EMIT;
                        end else begin
                            wcnt_nx  = wcnt + 4'd1;
                            state_nx = PAD;
                        end
                    end
                end
            end
            PAD: begin
                if (wcnt == 4'd14 && marker_done) begin
                    // length occupies the last two slots, written together
                    len_wr   = 1'b1;
                    final_nx = 1'b1;
                    state_nx = EMIT;
                end else begin
                    wr_en          = 1'b1;
                    wr_dat         = marker_done ? 32'h0 : 32'h8000_0000;
                    marker_done_nx = 1'b1;
                    if (wcnt == 4'd15) begin
                        final_nx     = 1'b0;
                        pad_after_nx = 1'b1;
                        state_nx     = EMIT;
                    end else begin
                        wcnt_nx = wcnt + 4'd1;
                    end
                end
            end
            EMIT: begin
                if (blk_ready) begin
                    first_pend_nx = 1'b0;
                    wcnt_nx       = 4'd0;
                    if (final_q) begin
                        state_nx       = ACCEPT;
                        bitcnt_nx      = '0;
                        first_pend_nx  = 1'b1;
                        marker_done_nx = 1'b0;
                        final_nx       = 1'b0;
                        pad_after_nx   = 1'b0;
                    end else begin
                        state_nx = pad_after ? PAD : ACCEPT;
                    end
                end
            end
            default: state_nx = ACCEPT;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACCEPT;
            wcnt        <= 4'd0;
            bitcnt      <= '0;
            first_pend  <= 1'b1;
            marker_done <= 1'b0;
            final_q     <= 1'b0;
            pad_after   <= 1'b0;
        end else begin
            state       <= state_nx;
            wcnt        <= wcnt_nx;
            bitcnt      <= bitcnt_nx;
            first_pend  <= first_pend_nx;
            marker_done <= marker_done_nx;
            final_q     <= final_nx;
            pad_after   <= pad_after_nx;
        end
    end

    // Block buffer: every slot is rewritten before each EMIT, so no reset is needed
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_q[wcnt] <= wr_dat;
        end
        if (len_wr) begin
            buf_q[14] <= len64[63:32];
            buf_q[15] <= len64[31:0];
        end
    end

    // Present the block only while held in EMIT, zero otherwise
    always_comb begin
        blk_data = '0;
        if (state == EMIT) begin
            for (int i = 0; i < 16; i++) begin
                blk_data[511-32*i -: 32] = buf_q[i];
            end
        end
    end

endmodule
